// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_TIMEOUT  = 2'd2,
        CAUSE_ILLEGAL  = 2'd3
    } cause_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic RstEnable = 1'b1;
    localparam logic ENABLE    = 1'b1;

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake bundle between a core and the LSU.
interface lsu_if #(
    parameter int AddressSize = 32,
    parameter int WordSize    = 32
);
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic                   req_we_i;
    logic [1:0]             req_size_i;
    logic                   req_unsigned_i;
    logic [AddressSize-1:0] req_addr_i;
    logic [WordSize-1:0]    req_wdata_i;
    logic                   resp_valid_o;
    logic                   resp_ready_i;
    logic [WordSize-1:0]    resp_rdata_o;
    logic                   resp_err_o;
    logic [1:0]             resp_cause_o;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  resp_ready_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, resp_cause_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, resp_cause_o
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane enables, store data replication and load extract/extend.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int WordSize = 32
) (
    input  size_e               size,
    input  logic [1:0]          addr_lo,
    input  logic                is_unsigned,
    input  logic [WordSize-1:0] wdata,
    input  logic [WordSize-1:0] load_data,
    output logic [3:0]          byte_en,
    output logic [WordSize-1:0] store_data,
    output logic [WordSize-1:0] load_value
);
    logic [WordSize-1:0] shifted;

    assign shifted = load_data >> {addr_lo, 3'b000};

    // Lane select, replication and extension all keyed on access size.
    always_comb begin
        byte_en    = 4'b0000;
        store_data = wdata;
        load_value = shifted;
        case (size)
            SIZE_BYTE: begin
                byte_en    = 4'b0001 << addr_lo;
                store_data = WordSize'({4{wdata[7:0]}});
                load_value = {{(WordSize-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                byte_en    = 4'b0011 << addr_lo;
                store_data = WordSize'({2{wdata[15:0]}});
                load_value = {{(WordSize-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
            end
            SIZE_WORD: begin
                byte_en = 4'b1111;
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end
endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request, runs a single memory access with
// timeout, then holds the response until the requester takes it.
module lsu
    import lsu_pkg::*;
#(
    parameter int AddressSize   = 32,
    parameter int WordSize      = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    lsu_if.slave                   bus,
    output logic [AddressSize-1:0] data_addr_o,
    output logic [WordSize-1:0]    store_data_o,
    input  logic [WordSize-1:0]    load_data_i,
    output logic                   MemR_en_o,
    output logic                   MemW_en_o,
    output logic [3:0]             byte_enable_o,
    input  logic                   read_valid_i,
    input  logic                   write_ready_i
);
    localparam int TimerWidth = $clog2(TimeoutCycles + 1);

    state_e                 state;
    logic [TimerWidth-1:0]  timer;
    logic                   req_we_q;
    size_e                  req_size_q;
    logic                   req_unsigned_q;
    logic [AddressSize-1:0] req_addr_q;
    logic [WordSize-1:0]    req_wdata_q;

    size_e                  in_size;
    size_e                  sel_size;
    logic                   sel_unsigned;
    logic [AddressSize-1:0] sel_addr;
    logic [WordSize-1:0]    sel_wdata;
    logic                   illegal_size;
    logic                   misaligned;
    logic                   load_done;
    logic                   store_done;
    logic [3:0]             align_be;
    logic [WordSize-1:0]    align_store;
    logic [WordSize-1:0]    align_load;

    assign in_size = size_e'(bus.req_size_i);

    // The aligner sees the incoming request while idle (to set up the access)
    // and the latched request afterwards (to extract load data).
    assign sel_size     = (state == IDLE) ? in_size : req_size_q;
    assign sel_unsigned = (state == IDLE) ? bus.req_unsigned_i : req_unsigned_q;
    assign sel_addr     = (state == IDLE) ? bus.req_addr_i : req_addr_q;
    assign sel_wdata    = (state == IDLE) ? bus.req_wdata_i : req_wdata_q;

    assign illegal_size = (in_size == SIZE_ILLEGAL);
    assign misaligned   = ((in_size == SIZE_HALF) && bus.req_addr_i[0]) ||
                          ((in_size == SIZE_WORD) && (bus.req_addr_i[1:0] != 2'b00));
    assign load_done    = MemR_en_o & read_valid_i;
    assign store_done   = MemW_en_o & write_ready_i;

    assign bus.req_ready_o = (state == IDLE);

    lsu_align #(.WordSize(WordSize)) u_align (
        .size        (sel_size),
        .addr_lo     (sel_addr[1:0]),
        .is_unsigned (sel_unsigned),
        .wdata       (sel_wdata),
        .load_data   (load_data_i),
        .byte_en     (align_be),
        .store_data  (align_store),
        .load_value  (align_load)
    );

    // Request/access/response sequencing with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state            <= IDLE;
            timer            <= '0;
            req_we_q         <= 1'b0;
            req_size_q       <= SIZE_BYTE;
            req_unsigned_q   <= 1'b0;
            req_addr_q       <= '0;
            req_wdata_q      <= '0;
            bus.resp_valid_o <= 1'b0;
            bus.resp_err_o   <= 1'b0;
            bus.resp_cause_o <= CAUSE_NONE;
            bus.resp_rdata_o <= '0;
            MemR_en_o        <= 1'b0;
            MemW_en_o        <= 1'b0;
            byte_enable_o    <= '0;
            data_addr_o      <= '0;
            store_data_o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        req_we_q       <= bus.req_we_i;
                        req_size_q     <= in_size;
                        req_unsigned_q <= bus.req_unsigned_i;
                        req_addr_q     <= bus.req_addr_i;
                        req_wdata_q    <= bus.req_wdata_i;
                        if (illegal_size || misaligned) begin
                            state            <= RESP;
                            bus.resp_valid_o <= ENABLE;
                            bus.resp_err_o   <= 1'b1;
                            bus.resp_cause_o <= illegal_size ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
                            bus.resp_rdata_o <= '0;
                        end else begin
                            state         <= ACCESS;
                            timer         <= TimerWidth'(TimeoutCycles);
                            MemR_en_o     <= ~bus.req_we_i;
                            MemW_en_o     <= bus.req_we_i;
                            data_addr_o   <= {sel_addr[AddressSize-1:2], 2'b00};
                            byte_enable_o <= bus.req_we_i ? align_be : 4'b0000;
                            store_data_o  <= bus.req_we_i ? align_store : '0;
                        end
                    end
                end
                ACCESS: begin
                    if (load_done || store_done || (timer == TimerWidth'(1))) begin
                        state            <= RESP;
                        timer            <= '0;
                        MemR_en_o        <= 1'b0;
                        MemW_en_o        <= 1'b0;
                        byte_enable_o    <= '0;
                        data_addr_o      <= '0;
                        store_data_o     <= '0;
                        bus.resp_valid_o <= ENABLE;
                        if (load_done || store_done) begin
                            bus.resp_err_o   <= 1'b0;
                            bus.resp_cause_o <= CAUSE_NONE;
                            bus.resp_rdata_o <= load_done ? align_load : '0;
                        end else begin
                            bus.resp_err_o   <= 1'b1;
                            bus.resp_cause_o <= CAUSE_TIMEOUT;
                            bus.resp_rdata_o <= '0;
                        end
                    end else begin
                        timer <= timer - TimerWidth'(1);
                    end
                end
                RESP: begin
                    if (bus.resp_ready_i) begin
                        state            <= IDLE;
                        bus.resp_valid_o <= 1'b0;
                        bus.resp_err_o   <= 1'b0;
                        bus.resp_cause_o <= CAUSE_NONE;
                        bus.resp_rdata_o <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: responses go through an expectation queue checked by
// a separate monitor; memory-side behaviour is checked inline.
module tb_lsu;
    import lsu_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  cause;
    } resp_t;

    logic        clk;
    logic        rst;
    logic [31:0] data_addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [3:0]  byte_en;
    logic        read_valid;
    logic        write_ready;

    int    checks = 0;
    int    errors = 0;
    int    memr_cycles = 0;
    int    write_edges = 0;
    resp_t exp_q[$];

    lsu_if #(.AddressSize(32), .WordSize(32)) bus ();

    lsu #(.AddressSize(32), .WordSize(32), .TimeoutCycles(16)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .data_addr_o   (data_addr),
        .store_data_o  (store_data),
        .load_data_i   (load_data),
        .MemR_en_o     (mem_r_en),
        .MemW_en_o     (mem_w_en),
        .byte_enable_o (byte_en),
        .read_valid_i  (read_valid),
        .write_ready_i (write_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_resp(input logic [31:0] rdata, input logic err, input logic [1:0] cause);
        resp_t r;
        r.rdata = rdata;
        r.err   = err;
        r.cause = cause;
        exp_q.push_back(r);
    endtask

    // Memory-side activity counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_r_en) memr_cycles++;
            if (mem_w_en && write_ready) write_edges++;
        end
    end

    // Response monitor: every handshaken response must match the queue head.
    always @(negedge clk) begin
        resp_t e;
        if (!rst && bus.resp_valid_o && bus.resp_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got rdata %h err %b cause %0d, none expected",
                         bus.resp_rdata_o, bus.resp_err_o, bus.resp_cause_o);
            end else begin
                e = exp_q.pop_front();
                check("resp_rdata", bus.resp_rdata_o, e.rdata);
                check("resp_err", 32'(bus.resp_err_o), 32'(e.err));
                check("resp_cause", 32'(bus.resp_cause_o), 32'(e.cause));
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        while (!bus.req_ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("issue_ready", 32'(bus.req_ready_o), 32'd1);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_size_i     = size;
        bus.req_unsigned_i = uns;
        bus.req_addr_i     = addr;
        bus.req_wdata_i    = wdata;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.req_ready_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idle", 32'(bus.req_ready_o), 32'd1);
    endtask

    initial begin
        int m0;
        int w0;
        int n;
        rst                = 1'b1;
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_size_i     = 2'b00;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = '0;
        bus.req_wdata_i    = '0;
        bus.resp_ready_i   = 1'b1;
        load_data          = '0;
        read_valid         = 1'b0;
        write_ready        = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
        check("rst_mem_en", {30'd0, mem_r_en, mem_w_en}, 32'd0);
        check("rst_data_addr", data_addr, 32'd0);

        // Store byte at 0x103 with a delayed write_ready.
        w0 = write_edges;
        expect_resp(32'd0, 1'b0, 2'd0);
        issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00AB);
        check("sb_wen", 32'(mem_w_en), 32'd1);
        check("sb_ren", 32'(mem_r_en), 32'd0);
        check("sb_be", 32'(byte_en), 32'h8);
        check("sb_sdata", store_data, 32'hABAB_ABAB);
        check("sb_addr", data_addr, 32'h100);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("sb_hold_be", 32'(byte_en), 32'h8);
        check("sb_hold_addr", data_addr, 32'h100);
        write_ready = 1'b1;
        @(posedge clk); #1;
        write_ready = 1'b0;
        check("sb_wen_drop", 32'(mem_w_en), 32'd0);
        wait_idle();
        check("sb_write_edges", 32'(write_edges - w0), 32'd1);

        // Half loads at 0x202, signed then unsigned.
        load_data  = 32'h8001_1234;
        read_valid = 1'b1;
        expect_resp(32'hFFFF_8001, 1'b0, 2'd0);
        issue(1'b0, 2'b01, 1'b0, 32'h202, 32'h0);
        check("lh_be", 32'(byte_en), 32'd0);
        check("lh_addr", data_addr, 32'h200);
        wait_idle();
        expect_resp(32'h0000_8001, 1'b0, 2'd0);
        issue(1'b0, 2'b01, 1'b1, 32'h202, 32'h0);
        wait_idle();

        // Misaligned word load.
        m0 = memr_cycles;
        expect_resp(32'd0, 1'b1, 2'd1);
        issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
        check("mis_resp_valid", 32'(bus.resp_valid_o), 32'd1);
        check("mis_ren", 32'(mem_r_en), 32'd0);
        wait_idle();
        check("mis_memr_cycles", 32'(memr_cycles - m0), 32'd0);

        // Load timeout with read_valid held low.
        read_valid = 1'b0;
        load_data  = 32'hDEAD_BEEF;
        m0 = memr_cycles;
        expect_resp(32'd0, 1'b1, 2'd2);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        wait_idle();
        check("to_memr_cycles", 32'(memr_cycles - m0), 32'd16);

        // Completion on the final timeout edge wins.
        load_data = 32'h0000_00C3;
        m0 = memr_cycles;
        expect_resp(32'h0000_00C3, 1'b0, 2'd0);
        issue(1'b0, 2'b00, 1'b1, 32'h8, 32'h0);
        repeat (15) begin
            @(posedge clk); #1;
        end
        check("edge_ren_still", 32'(mem_r_en), 32'd1);
        read_valid = 1'b1;
        @(posedge clk); #1;
        read_valid = 1'b0;
        wait_idle();
        check("edge_memr_cycles", 32'(memr_cycles - m0), 32'd16);

        // Response back-pressure, then a request waiting across RESP exit.
        bus.resp_ready_i = 1'b0;
        load_data  = 32'h9A00_0000;
        read_valid = 1'b1;
        expect_resp(32'hFFFF_FF9A, 1'b0, 2'd0);
        issue(1'b0, 2'b00, 1'b0, 32'h3, 32'h0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.resp_valid_o), 32'd1);
            check("bp_rdata", bus.resp_rdata_o, 32'hFFFF_FF9A);
            check("bp_req_ready", 32'(bus.req_ready_o), 32'd0);
            @(posedge clk); #1;
        end
        expect_resp(32'h1122_3344, 1'b0, 2'd0);
        bus.resp_ready_i   = 1'b1;
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = 1'b0;
        bus.req_size_i     = 2'b10;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = 32'h40;
        @(posedge clk); #1;
        load_data = 32'h1122_3344;
        check("b2b_ready_after_exit", 32'(bus.req_ready_o), 32'd1);
        check("b2b_no_accept", 32'(mem_r_en), 32'd0);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        check("b2b_accept_ren", 32'(mem_r_en), 32'd1);
        wait_idle();
        read_valid = 1'b0;

        // Store half with immediate write_ready, lane-shifted replication.
        w0 = write_edges;
        write_ready = 1'b1;
        expect_resp(32'd0, 1'b0, 2'd0);
        issue(1'b1, 2'b01, 1'b0, 32'h2, 32'h1234_ABCD);
        check("sh_be", 32'(byte_en), 32'hC);
        check("sh_sdata", store_data, 32'hABCD_ABCD);
        check("sh_addr", data_addr, 32'h0);
        @(posedge clk); #1;
        check("sh_wen_drop", 32'(mem_w_en), 32'd0);
        wait_idle();
        check("sh_write_edges", 32'(write_edges - w0), 32'd1);

        // Misaligned half store and illegal size: no memory activity.
        w0 = write_edges;
        expect_resp(32'd0, 1'b1, 2'd1);
        issue(1'b1, 2'b01, 1'b0, 32'h1, 32'h5555_5555);
        check("mis_st_wen", 32'(mem_w_en), 32'd0);
        wait_idle();
        check("mis_st_edges", 32'(write_edges - w0), 32'd0);
        expect_resp(32'd0, 1'b1, 2'd3);
        issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
        check("ill_ren", 32'(mem_r_en), 32'd0);
        wait_idle();
        write_ready = 1'b0;

        // Reset in the middle of a stalled store.
        w0 = write_edges;
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h0000_0055);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_wen", 32'(mem_w_en), 32'd0);
        check("rst_mid_ren", 32'(mem_r_en), 32'd0);
        check("rst_mid_be", 32'(byte_en), 32'd0);
        check("rst_mid_addr", data_addr, 32'd0);
        check("rst_mid_sdata", store_data, 32'd0);
        check("rst_mid_resp", {28'd0, bus.resp_valid_o, bus.resp_err_o, bus.resp_cause_o}, 32'd0);
        check("rst_mid_rdata", bus.resp_rdata_o, 32'd0);
        check("rst_mid_ready", 32'(bus.req_ready_o), 32'd1);
        check("rst_mid_edges", 32'(write_edges - w0), 32'd0);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
